pipeline_ctrl: RTL and testbench

Consumer of the hazard unit's outputs: turns load-use stall requests, cache hit/miss status, branch/jump resolution and halt into per-latch enable/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It sits beside the hazard unit in the pipelined datapath. Forwarding selects bypass it. It owns the multi-cycle stall sequencing, the sticky halt, and two saturating performance counters.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/sat_counter.sv | 25 ++
 rtl/pipeline_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: control FSM state encoding and counter width default.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

  // Pipeline control FSM states
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LUSTALL = 2'd1,
    HALT    = 2'd2
  } ctrl_state_t;

  // Default width of the performance counters
  localparam int CNT_W_DEF = 16;

  // Bubble counter preload on load-use entry: one bubble needs no extra
  // cycle, two bubbles need one more cycle after the entry cycle.
  function automatic logic [1:0] lu_preload(input logic [1:0] stall_req);
    return (stall_req == 2'd1) ? 2'd0 : 2'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
// Latency: count updates on the rising edge after inc is sampled.
// Backpressure: none; inc is ignored once saturated.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, hold at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline latch enable/flush sequencer: load-use bubbles, cache-miss freeze, branch/jump flush, sticky halt.
// Latency: controls are combinational (Mealy) from state and inputs; state/halted/counters update next edge.
// Backpressure: a pending data miss freezes PC..EX/MEM and drains a bubble into MEM/WB until dhit.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       StallLW,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             EXMEM_dREN,
  input  logic             EXMEM_dWEN,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             MEMWB_halt,
  output logic             PC_en,
  output logic             IFID_en,
  output logic             IDEX_en,
  output logic             EXMEM_en,
  output logic             MEMWB_en,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             EXMEM_flush,
  output logic             MEMWB_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  ctrl_state_t state, state_n;
  logic [1:0]  lu_cnt, lu_n;
  logic [1:0]  lu_eff;
  logic        mem_wait;
  logic        flush_inc;
  logic        stall_inc;

  assign mem_wait = (EXMEM_dREN | EXMEM_dWEN) & ~dhit;

  // The halt flag is exactly "FSM sits in HALT", so it is registered via state
  assign halted = (state == HALT);

  // State and bubble counter registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= RUN;
      lu_cnt <= 2'd0;
    end else begin
      state  <= state_n;
      lu_cnt <= lu_n;
    end
  end

  // Prioritised next-state and latch control decode
  always_comb begin
    state_n     = state;
    lu_n        = lu_cnt;
    lu_eff      = lu_cnt;
    flush_inc   = 1'b0;
    PC_en       = 1'b1;
    IFID_en     = 1'b1;
    IDEX_en     = 1'b1;
    EXMEM_en    = 1'b1;
    MEMWB_en    = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    EXMEM_flush = 1'b0;
    MEMWB_flush = 1'b0;

    if (RST) begin
      // Hold every latch while reset is asserted
      PC_en    = 1'b0;
      IFID_en  = 1'b0;
      IDEX_en  = 1'b0;
      EXMEM_en = 1'b0;
      MEMWB_en = 1'b0;
    end else if (state == HALT) begin
      PC_en    = 1'b0;
      IFID_en  = 1'b0;
      IDEX_en  = 1'b0;
      EXMEM_en = 1'b0;
      MEMWB_en = 1'b0;
    end else if (MEMWB_halt) begin
      // Halt retires normally this cycle; everything stops from the next one
      state_n = HALT;
    end else if (mem_wait) begin
      // Freeze the front of the pipe, push a bubble past the stalled MEM stage
      PC_en       = 1'b0;
      IFID_en     = 1'b0;
      IDEX_en     = 1'b0;
      EXMEM_en    = 1'b0;
      MEMWB_flush = 1'b1;
    end else if (branch_taken) begin
      // Squash the two younger instructions; redirect wins over any bubble sequence
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
      state_n    = RUN;
      lu_n       = 2'd0;
      flush_inc  = 1'b1;
    end else if ((state == LUSTALL) || (StallLW != 2'd0)) begin
      // Load-use bubble: hold PC and IF/ID, inject a bubble into ID/EX.
      // The entry cycle is itself the first bubble.
      PC_en      = 1'b0;
      IFID_en    = 1'b0;
      IDEX_flush = 1'b1;
      if (state == RUN) begin
        lu_eff = lu_preload(StallLW);
      end
      if (lu_eff == 2'd0) begin
        state_n = RUN;
        lu_n    = 2'd0;
      end else begin
        state_n = LUSTALL;
        lu_n    = lu_eff - 2'd1;
      end
    end else if (jump) begin
      IFID_flush = 1'b1;
      flush_inc  = 1'b1;
    end else if (!ihit) begin
      PC_en      = 1'b0;
      IFID_flush = 1'b1;
    end
  end

  // A stalled cycle is any live (non-halted, non-reset) cycle that holds the PC
  assign stall_inc = ~RST & (state != HALT) & ~PC_en;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clear (1'b0),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clear (1'b0),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a 16-bit-counter instance and a 4-bit-counter instance share stimulus.
// Latency: expected controls are checked mid-cycle (negedge) for inputs applied just after posedge.
// Backpressure: n/a.
module tb_pipeline_ctrl;

  // Output vector order: {PC, IFID_en, IDEX_en, EXMEM_en, MEMWB_en, IFID_fl, IDEX_fl, EXMEM_fl, MEMWB_fl}
  localparam logic [8:0] O_RUN  = 9'b1_1111_0000;
  localparam logic [8:0] O_BUB  = 9'b0_0111_0100;
  localparam logic [8:0] O_FRZ  = 9'b0_0001_0001;
  localparam logic [8:0] O_BR   = 9'b1_1111_1100;
  localparam logic [8:0] O_JMP  = 9'b1_1111_1000;
  localparam logic [8:0] O_MISS = 9'b0_1111_1000;
  localparam logic [8:0] O_OFF  = 9'b0_0000_0000;

  typedef struct packed {
    logic [8:0]  o;
    logic [31:0] s;
    logic [31:0] f;
    logic        h;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  stall_lw;
  logic        ihit, dhit, dren, dwen, br, jmp, mhalt;

  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_fl, idex_fl, exmem_fl, memwb_fl, halted;
  logic [15:0] stall_cycles, flush_count;

  logic        pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4;
  logic        ifid_fl4, idex_fl4, exmem_fl4, memwb_fl4, halted4;
  logic [3:0]  stall_cycles4, flush_count4;

  logic [8:0]  o_main, o_small;
  exp_t        sb[$];
  int          n_chk;
  int          n_pass;

  pipeline_ctrl #(.CNT_W(16)) dut (
    .CLK(clk), .RST(rst), .StallLW(stall_lw), .ihit(ihit), .dhit(dhit),
    .EXMEM_dREN(dren), .EXMEM_dWEN(dwen), .branch_taken(br), .jump(jmp),
    .MEMWB_halt(mhalt),
    .PC_en(pc_en), .IFID_en(ifid_en), .IDEX_en(idex_en), .EXMEM_en(exmem_en),
    .MEMWB_en(memwb_en), .IFID_flush(ifid_fl), .IDEX_flush(idex_fl),
    .EXMEM_flush(exmem_fl), .MEMWB_flush(memwb_fl), .halted(halted),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  pipeline_ctrl #(.CNT_W(4)) dut4 (
    .CLK(clk), .RST(rst), .StallLW(stall_lw), .ihit(ihit), .dhit(dhit),
    .EXMEM_dREN(dren), .EXMEM_dWEN(dwen), .branch_taken(br), .jump(jmp),
    .MEMWB_halt(mhalt),
    .PC_en(pc_en4), .IFID_en(ifid_en4), .IDEX_en(idex_en4), .EXMEM_en(exmem_en4),
    .MEMWB_en(memwb_en4), .IFID_flush(ifid_fl4), .IDEX_flush(idex_fl4),
    .EXMEM_flush(exmem_fl4), .MEMWB_flush(memwb_fl4), .halted(halted4),
    .stall_cycles(stall_cycles4), .flush_count(flush_count4)
  );

  assign o_main  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_fl, idex_fl, exmem_fl, memwb_fl};
  assign o_small = {pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4,
                    ifid_fl4, idex_fl4, exmem_fl4, memwb_fl4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat15(input logic [31:0] v);
    return (v > 32'd15) ? 32'd15 : v;
  endfunction

  // Pop one expectation per cycle and compare mid-cycle, away from the clock edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("ctrl",    {23'd0, o_main},        {23'd0, e.o});
      chk("ctrl4",   {23'd0, o_small},       {23'd0, e.o});
      chk("halted",  {31'd0, halted},        {31'd0, e.h});
      chk("stall",   {16'd0, stall_cycles},  e.s);
      chk("flush",   {16'd0, flush_count},   e.f);
      chk("stall4",  {28'd0, stall_cycles4}, sat15(e.s));
      chk("flush4",  {28'd0, flush_count4},  sat15(e.f));
    end
  end

  // Apply one cycle of inputs and queue what the DUT must show for it
  task automatic drive(input logic [1:0] st, input logic ih, input logic dh,
                       input logic dr, input logic dw, input logic b, input logic j,
                       input logic hl, input logic [8:0] eo, input int es,
                       input int ef, input logic eh);
    exp_t e;
    stall_lw = st; ihit = ih; dhit = dh; dren = dr; dwen = dw;
    br = b; jmp = j; mhalt = hl;
    e.o = eo; e.s = es; e.f = ef; e.h = eh;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [8:0] eo, input int es, input int ef, input logic eh);
    drive(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, eo, es, ef, eh);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    stall_lw = 2'd0; ihit = 1'b1; dhit = 1'b1; dren = 1'b0; dwen = 1'b0;
    br = 1'b0; jmp = 1'b0; mhalt = 1'b0;
    @(posedge clk);
    #1;

    // Reset holds every latch
    idle(O_OFF, 0, 0, 1'b0);
    idle(O_OFF, 0, 0, 1'b0);
    rst = 1'b0;
    idle(O_RUN, 0, 0, 1'b0);

    // Single load-use bubble
    drive(2'd1, 1, 1, 0, 0, 0, 0, 0, O_BUB, 0, 0, 1'b0);
    idle(O_RUN, 1, 0, 1'b0);

    // Double bubble, second bubble extended by a 3-cycle data miss
    drive(2'd2, 1, 1, 0, 0, 0, 0, 0, O_BUB, 1, 0, 1'b0);
    for (int i = 0; i < 3; i++) drive(2'd0, 1, 0, 1, 0, 0, 0, 0, O_FRZ, 2 + i, 0, 1'b0);
    idle(O_BUB, 5, 0, 1'b0);
    idle(O_RUN, 6, 0, 1'b0);

    // Branch aborts a double bubble
    drive(2'd2, 1, 1, 0, 0, 0, 0, 0, O_BUB, 6, 0, 1'b0);
    drive(2'd0, 1, 1, 0, 0, 1, 0, 0, O_BR, 7, 0, 1'b0);
    idle(O_RUN, 7, 1, 1'b0);

    // Branch + jump + I-miss together: branch wins, one flush event
    drive(2'd0, 0, 1, 0, 0, 1, 1, 0, O_BR, 7, 1, 1'b0);
    idle(O_RUN, 7, 2, 1'b0);

    // Jump alone, then I-miss alone
    drive(2'd0, 1, 1, 0, 0, 0, 1, 0, O_JMP, 7, 2, 1'b0);
    drive(2'd0, 0, 1, 0, 0, 0, 0, 0, O_MISS, 7, 3, 1'b0);
    idle(O_RUN, 8, 3, 1'b0);

    // StallLW=3 gives two bubbles
    drive(2'd3, 1, 1, 0, 0, 0, 0, 0, O_BUB, 8, 3, 1'b0);
    idle(O_BUB, 9, 3, 1'b0);
    idle(O_RUN, 10, 3, 1'b0);

    // Store miss outranks a jump: no flush counted
    drive(2'd0, 1, 0, 0, 1, 0, 1, 0, O_FRZ, 10, 3, 1'b0);
    idle(O_RUN, 11, 3, 1'b0);

    // Halt: current cycle normal, then frozen for 100 cycles whatever the inputs
    drive(2'd0, 1, 1, 0, 0, 0, 0, 1, O_RUN, 11, 3, 1'b0);
    for (int i = 0; i < 100; i++) begin
      drive(2'(i % 4), (i % 3) != 0, (i % 2) == 0, (i % 5) == 0, 1'b0,
            (i % 7) == 0, (i % 11) == 0, 1'b0, O_OFF, 11, 3, 1'b1);
    end

    // Reset mid-halt clears flag and counters
    rst = 1'b1;
    idle(O_OFF, 0, 0, 1'b0);
    rst = 1'b0;
    idle(O_RUN, 0, 0, 1'b0);

    // Reset mid-stall returns to RUN
    drive(2'd2, 1, 1, 0, 0, 0, 0, 0, O_BUB, 0, 0, 1'b0);
    rst = 1'b1;
    idle(O_OFF, 0, 0, 1'b0);
    rst = 1'b0;
    idle(O_RUN, 0, 0, 1'b0);

    // Saturation: 20 I-miss cycles, 4-bit counter stops at 15
    for (int i = 0; i < 20; i++) drive(2'd0, 0, 1, 0, 0, 0, 0, 0, O_MISS, i, 0, 1'b0);
    idle(O_RUN, 20, 0, 1'b0);

    @(negedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
